// File: rtl/cnn_pkg.sv
// Shared CNN pipeline constants, pooling-step decode type and a signed max helper.
package cnn_pkg;

    localparam int unsigned DATA_W_DEF = 24;
    localparam int unsigned IMG_W_C1   = 26;
    localparam int unsigned IMG_H_C1   = 26;

    // Widest pixel the max helper handles; narrower operands are sign-extended into it.
    localparam int unsigned MAX_W = 64;

    typedef enum logic [2:0] {
        ACT_IDLE,
        ACT_LATCH,
        ACT_STORE,
        ACT_EMIT,
        ACT_SKIP
    } pix_act_e;

    function automatic logic signed [MAX_W-1:0] signed_max(
        input logic signed [MAX_W-1:0] a,
        input logic signed [MAX_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Valid-only pixel stream into the pooler and pooled stream out of it.
interface maxpool2x2_stream_if import cnn_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic                     valid_in;
    logic signed [DATA_W-1:0] in;
    logic                     valid_out;
    logic signed [DATA_W-1:0] out;
    logic                     frame_done;

    modport master (
        output valid_in,
        output in,
        input  valid_out,
        input  out,
        input  frame_done
    );

    modport slave (
        input  valid_in,
        input  in,
        output valid_out,
        output out,
        output frame_done
    );

endinterface

// File: rtl/pool_line_buf.sv
// Simple dual-port line buffer: one synchronous write port, one combinational read port.
module pool_line_buf #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned DEPTH  = 13,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool over a raster-order valid-qualified pixel stream.
module maxpool2x2_stream import cnn_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned IMG_W  = IMG_W_C1,
    parameter int unsigned IMG_H  = IMG_H_C1
) (
    input logic                clk,
    input logic                rst,
    maxpool2x2_stream_if.slave strm
);

    localparam int unsigned OUT_W  = IMG_W / 2;
    localparam int unsigned OUT_H  = IMG_H / 2;
    localparam int unsigned COL_W  = $clog2(IMG_W);
    localparam int unsigned ROW_W  = $clog2(IMG_H);
    localparam int unsigned ADDR_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam bit          ODD_H  = (IMG_H % 2) != 0;

    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic signed [DATA_W-1:0] pair_q, pair_d;
    logic signed [DATA_W-1:0] out_q, out_d;
    logic                     valid_q, valid_d;
    logic                     done_q, done_d;

    pix_act_e                 act;
    logic                     col_last;
    logic                     row_last;
    logic [ADDR_W-1:0]        lb_addr;
    logic [DATA_W-1:0]        lb_rdata;
    logic signed [DATA_W-1:0] hmax;
    logic signed [DATA_W-1:0] vmax;

    assign col_last = (col_q == COL_W'(IMG_W - 1));
    assign row_last = (row_q == ROW_W'(IMG_H - 1));
    assign lb_addr  = ADDR_W'(col_q >> 1);

    assign hmax = DATA_W'(signed_max(MAX_W'(pair_q), MAX_W'(strm.in)));
    assign vmax = DATA_W'(signed_max(MAX_W'(hmax), MAX_W'($signed(lb_rdata))));

    // Odd-width trailing column lands on an even index and only latches pair_q,
    // which the next row's first pixel overwrites, so it never reaches the buffer.
    always_comb begin
        act = ACT_IDLE;
        if (strm.valid_in) begin
            if (!col_q[0]) begin
                act = ACT_LATCH;
            end else if (ODD_H && row_last) begin
                act = ACT_SKIP;
            end else if (!row_q[0]) begin
                act = ACT_STORE;
            end else begin
                act = ACT_EMIT;
            end
        end
    end

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        pair_d  = pair_q;
        out_d   = out_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        if (strm.valid_in) begin
            col_d = col_last ? '0 : col_q + COL_W'(1);
            if (col_last) begin
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end
        end

        case (act)
            ACT_LATCH: pair_d = strm.in;
            ACT_EMIT: begin
                out_d   = vmax;
                valid_d = 1'b1;
                done_d  = (row_q == ROW_W'(2 * OUT_H - 1)) &&
                          (col_q == COL_W'(2 * OUT_W - 1));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            pair_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            pair_q  <= pair_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    pool_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (OUT_W),
        .ADDR_W (ADDR_W)
    ) u_line_buf (
        .clk     (clk),
        .we_i    (act == ACT_STORE),
        .waddr_i (lb_addr),
        .wdata_i (hmax),
        .raddr_i (lb_addr),
        .rdata_o (lb_rdata)
    );

    assign strm.valid_out  = valid_q;
    assign strm.out        = out_q;
    assign strm.frame_done = done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream: vector table, directed corner sequences, random frames vs a window model.
module tb_maxpool2x2_stream;
    import cnn_pkg::*;

    localparam int DW = 24;
    typedef logic signed [DW-1:0] pix_t;
    typedef struct { pix_t v; int cyc; logic fd; } obs_t;
    typedef struct { pix_t pix; logic exp_v; pix_t exp_out; logic exp_fd; } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic dv [4];
    pix_t dd [4];
    logic vo [4];
    pix_t oo [4];
    logic fo [4];

    maxpool2x2_stream_if #(.DATA_W(DW)) if0 ();
    maxpool2x2_stream_if #(.DATA_W(DW)) if1 ();
    maxpool2x2_stream_if #(.DATA_W(DW)) if2 ();
    maxpool2x2_stream_if #(.DATA_W(DW)) if3 ();

    maxpool2x2_stream #(.DATA_W(DW), .IMG_W(4), .IMG_H(4))
        dut0 (.clk(clk), .rst(rst), .strm(if0));
    maxpool2x2_stream #(.DATA_W(DW), .IMG_W(4), .IMG_H(2))
        dut1 (.clk(clk), .rst(rst), .strm(if1));
    maxpool2x2_stream #(.DATA_W(DW), .IMG_W(5), .IMG_H(3))
        dut2 (.clk(clk), .rst(rst), .strm(if2));
    maxpool2x2_stream #(.DATA_W(DW), .IMG_W(IMG_W_C1), .IMG_H(IMG_H_C1))
        dut3 (.clk(clk), .rst(rst), .strm(if3));

    assign if0.valid_in = dv[0]; assign if0.in = dd[0];
    assign if1.valid_in = dv[1]; assign if1.in = dd[1];
    assign if2.valid_in = dv[2]; assign if2.in = dd[2];
    assign if3.valid_in = dv[3]; assign if3.in = dd[3];
    assign vo[0] = if0.valid_out; assign oo[0] = if0.out; assign fo[0] = if0.frame_done;
    assign vo[1] = if1.valid_out; assign oo[1] = if1.out; assign fo[1] = if1.frame_done;
    assign vo[2] = if2.valid_out; assign oo[2] = if2.out; assign fo[2] = if2.frame_done;
    assign vo[3] = if3.valid_out; assign oo[3] = if3.out; assign fo[3] = if3.frame_done;

    obs_t obs_q [4][$];
    pix_t px_q [$];
    int   acc_q [$];
    obs_t exp_q [$];

    always @(negedge clk) begin
        for (int s = 0; s < 4; s++) begin
            if (vo[s] || fo[s]) begin
                obs_t o;
                o.v   = oo[s];
                o.cyc = cyc;
                o.fd  = fo[s];
                obs_q[s].push_back(o);
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Called at a negedge; drives one pixel after an optional random idle gap.
    task automatic send_px(input int sel, input pix_t v, input int duty);
        int idle;
        idle = 0;
        while (duty < 100 && idle < 6 && int'($urandom_range(99)) >= duty) begin
            dv[sel] = 1'b0;
            dd[sel] = pix_t'($urandom);
            idle++;
            @(negedge clk);
        end
        dv[sel] = 1'b1;
        dd[sel] = v;
        px_q.push_back(v);
        acc_q.push_back(cyc + 1);
        @(negedge clk);
    endtask

    task automatic stop_px(input int sel);
        dv[sel] = 1'b0;
        @(negedge clk);
    endtask

    // Reference: every complete 2x2 window of each frame, emitted when its bottom-right pixel is accepted.
    task automatic build_exp(input int w, input int h);
        exp_q.delete();
        for (int f = 0; f * w * h < px_q.size(); f++) begin
            for (int r = 0; r < h / 2; r++) begin
                for (int c = 0; c < w / 2; c++) begin
                    int   b;
                    pix_t m;
                    obs_t e;
                    b = f * w * h + 2 * r * w + 2 * c;
                    if (b + w + 1 >= px_q.size()) continue;
                    m = px_q[b];
                    if (px_q[b + 1] > m) m = px_q[b + 1];
                    if (px_q[b + w] > m) m = px_q[b + w];
                    if (px_q[b + w + 1] > m) m = px_q[b + w + 1];
                    e.v   = m;
                    e.cyc = acc_q[b + w + 1];
                    e.fd  = (r == h / 2 - 1) && (c == w / 2 - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic check_run(input int sel, input string nm);
        repeat (3) @(negedge clk);
        chk({nm, " count"}, longint'(obs_q[sel].size()), longint'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= obs_q[sel].size()) break;
            chk($sformatf("%s[%0d] value", nm, i), longint'(obs_q[sel][i].v), longint'(exp_q[i].v));
            chk($sformatf("%s[%0d] cycle", nm, i), longint'(obs_q[sel][i].cyc), longint'(exp_q[i].cyc));
            chk($sformatf("%s[%0d] frame_done", nm, i), longint'(obs_q[sel][i].fd), longint'(exp_q[i].fd));
        end
        obs_q[sel].delete();
        px_q.delete();
        acc_q.delete();
    endtask

    task automatic run_frames(input int sel, input int w, input int h, input int frames,
                              input int duty, input bit rnd, input string nm);
        for (int f = 0; f < frames; f++) begin
            for (int i = 1; i <= w * h; i++) begin
                send_px(sel, rnd ? pix_t'($urandom) : pix_t'(i + 100 * f), duty);
            end
        end
        stop_px(sel);
        build_exp(w, h);
        check_run(sel, nm);
    endtask

    vec_t tbl [16];
    pix_t sgn [8];

    initial begin
        tbl = '{
            '{pix_t'(1),  1'b0, pix_t'(0),  1'b0},
            '{pix_t'(2),  1'b0, pix_t'(0),  1'b0},
            '{pix_t'(3),  1'b0, pix_t'(0),  1'b0},
            '{pix_t'(4),  1'b0, pix_t'(0),  1'b0},
            '{pix_t'(5),  1'b0, pix_t'(0),  1'b0},
            '{pix_t'(6),  1'b1, pix_t'(6),  1'b0},
            '{pix_t'(7),  1'b0, pix_t'(6),  1'b0},
            '{pix_t'(8),  1'b1, pix_t'(8),  1'b0},
            '{pix_t'(9),  1'b0, pix_t'(8),  1'b0},
            '{pix_t'(10), 1'b0, pix_t'(8),  1'b0},
            '{pix_t'(11), 1'b0, pix_t'(8),  1'b0},
            '{pix_t'(12), 1'b0, pix_t'(8),  1'b0},
            '{pix_t'(13), 1'b0, pix_t'(8),  1'b0},
            '{pix_t'(14), 1'b1, pix_t'(14), 1'b0},
            '{pix_t'(15), 1'b0, pix_t'(14), 1'b0},
            '{pix_t'(16), 1'b1, pix_t'(16), 1'b1}
        };
        sgn = '{pix_t'(-5), pix_t'(-3), pix_t'(-8), pix_t'(-1),
                pix_t'(-7), pix_t'(-4), pix_t'(-2), pix_t'(-9)};

        rst = 1'b1;
        for (int s = 0; s < 4; s++) begin
            dv[s] = 1'b0;
            dd[s] = '0;
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("reset valid_out[%0d]", s), longint'(vo[s]), 0);
            chk($sformatf("reset out[%0d]", s), longint'(oo[s]), 0);
            chk($sformatf("reset frame_done[%0d]", s), longint'(fo[s]), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Basic 4x4 contiguous frame, checked every cycle.
        for (int i = 0; i < 16; i++) begin
            dv[0] = 1'b1;
            dd[0] = tbl[i].pix;
            @(negedge clk);
            chk($sformatf("tbl[%0d] valid_out", i), longint'(vo[0]), longint'(tbl[i].exp_v));
            chk($sformatf("tbl[%0d] out", i), longint'(oo[0]), longint'(tbl[i].exp_out));
            chk($sformatf("tbl[%0d] frame_done", i), longint'(fo[0]), longint'(tbl[i].exp_fd));
        end
        stop_px(0);
        chk("tbl idle valid_out", longint'(vo[0]), 0);
        chk("tbl idle out held", longint'(oo[0]), 16);
        obs_q[0].delete();

        // Signed 4x2 frame.
        for (int i = 0; i < 8; i++) send_px(1, sgn[i], 100);
        stop_px(1);
        build_exp(4, 2);
        chk("signed model first", longint'(exp_q[0].v), -3);
        check_run(1, "signed");

        run_frames(0, 4, 4, 1, 50, 1'b0, "gaps");
        run_frames(2, 5, 3, 2, 100, 1'b0, "odd5x3");
        run_frames(0, 4, 4, 2, 100, 1'b0, "b2b");

        // Reset mid-frame after 6 pixels, then a clean frame.
        for (int i = 1; i <= 6; i++) send_px(0, pix_t'(i), 100);
        stop_px(0);
        build_exp(4, 4);
        check_run(0, "partial");
        rst = 1'b1;
        #1;
        chk("midrst valid_out", longint'(vo[0]), 0);
        chk("midrst out", longint'(oo[0]), 0);
        chk("midrst frame_done", longint'(fo[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        obs_q[0].delete();
        run_frames(0, 4, 4, 1, 100, 1'b0, "after_rst");

        run_frames(1, 4, 2, 4, 60, 1'b1, "rand4x2");
        run_frames(0, 4, 4, 3, 40, 1'b1, "rand4x4");
        run_frames(3, IMG_W_C1, IMG_H_C1, 2, 60, 1'b1, "rand26");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
